imem_loader: RTL

Byte-stream program loader that is the writing end of the instruction-memory interface the core's fetch stages read. It accepts framed bytes over a valid/ready handshake, assembles them into instruction words and drives one write port of the instruction memory. It holds the core in reset until a frame with a correct checksum has completed. It sits beside the core top level, sharing its clock; its hold output is ORed into the core's reset.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader driving one instruction-memory
// write port. It parses framed bytes, assembles big-endian words, writes
// them to consecutive addresses and holds the core in reset until a frame
// with a good checksum has completed.
//
// Frame: SYNC | AB addr bytes (BE) | 2 count bytes (BE) | N*WB data | csum
// csum = XOR of every byte after SYNC, not counting the checksum byte.
//
// Ports:
//   iw_clk, iw_rst_n   clock (rising edge), async active-low reset
//   iw_valid, iw_data  byte stream in; accepted when iw_valid & ow_ready
//   ow_ready           low only in the END cycle
//   ow_mem_we/addr/wdata  one-cycle write strobe plus address/data
//   ow_cpu_hold        core reset hold, ~loaded
//   or_busy            frame in progress
//   or_done / or_err   one-cycle pulses at END: checksum good / bad
module imem_loader #(
  parameter int          DATA_W = 24,
  parameter int          ADDR_W = 24,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_valid,
  input  logic [7:0]        iw_data,
  output logic              ow_ready,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  output logic              ow_cpu_hold,
  output logic              or_busy,
  output logic              or_done,
  output logic              or_err
);

  localparam int WB   = DATA_W / 8;
  localparam int AB   = ADDR_W / 8;
  // Byte counter must reach WB-1, AB-1 and 1 (two length bytes).
  localparam int MAXB = (WB > AB) ? ((WB > 2) ? WB : 2) : ((AB > 2) ? AB : 2);
  localparam int CW   = $clog2(MAXB);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  logic [2:0]        state;
  logic [7:0]        acc;
  logic              loaded;
  logic [CW-1:0]     bcnt;
  logic [15:0]       len;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] word;
  logic              take;

  assign ow_ready    = (state != S_END);
  assign or_busy     = (state != S_IDLE);
  assign ow_cpu_hold = ~loaded;
  assign take        = iw_valid & ow_ready;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state        <= S_IDLE;
      acc          <= '0;
      loaded       <= 1'b0;
      bcnt         <= '0;
      len          <= '0;
      cur_addr     <= '0;
      word         <= '0;
      ow_mem_we    <= 1'b0;
      ow_mem_addr  <= '0;
      ow_mem_wdata <= '0;
      or_done      <= 1'b0;
      or_err       <= 1'b0;
    end else begin
      // strobes and pulses are single-cycle by default
      ow_mem_we <= 1'b0;
      or_done   <= 1'b0;
      or_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take && iw_data == SYNC) begin
            state  <= S_ADDR;
            acc    <= '0;
            loaded <= 1'b0;
            bcnt   <= '0;
          end
        end
        S_ADDR: begin
          if (take) begin
            acc      <= acc ^ iw_data;
            cur_addr <= ADDR_W'({cur_addr, iw_data});
            if (bcnt == CW'(AB - 1)) begin
              bcnt  <= '0;
              state <= S_LEN;
            end else begin
              bcnt <= bcnt + CW'(1);
            end
          end
        end
        S_LEN: begin
          if (take) begin
            acc <= acc ^ iw_data;
            len <= {len[7:0], iw_data};
            if (bcnt == CW'(1)) begin
              bcnt  <= '0;
              state <= ({len[7:0], iw_data} == 16'd0) ? S_CSUM : S_DATA;
            end else begin
              bcnt <= bcnt + CW'(1);
            end
          end
        end
        S_DATA: begin
          if (take) begin
            acc  <= acc ^ iw_data;
            word <= DATA_W'({word, iw_data});
            if (bcnt == CW'(WB - 1)) begin
              // last byte of the word: write next cycle, advance address
              bcnt         <= '0;
              ow_mem_we    <= 1'b1;
              ow_mem_addr  <= cur_addr;
              ow_mem_wdata <= DATA_W'({word, iw_data});
              cur_addr     <= cur_addr + ADDR_W'(1);
              len          <= len - 16'd1;
              if (len == 16'd1) state <= S_CSUM;
            end else begin
              bcnt <= bcnt + CW'(1);
            end
          end
        end
        S_CSUM: begin
          // result registered here so the pulse lands in the END cycle
          if (take) begin
            or_done <= (iw_data == acc);
            or_err  <= (iw_data != acc);
            state   <= S_END;
          end
        end
        S_END: begin
          if (or_done) loaded <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
